// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and default bit timing.
// The receiver is intended to import the same package so both ends agree.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY_BIT = 3'd3,
      STOP       = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // 100 MHz clock at 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks within one serial bit and pulses bit_done_out
// on the final cycle of each bit. Held at zero whenever the transmitter is idle.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear_in,
   input  logic run_in,
   output logic bit_done_out
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_in || !run_in || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign bit_done_out = run_in && !clear_in && (cnt_q == LAST);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, one stop bit.
// The serial line is registered so it never glitches between bit periods.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int PARITY       = PARITY_NONE
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 uart_tx_en_in,
   input  logic [DATA_BITS-1:0] uart_tx_data_in,
   output logic                 uart_tx_ready_out,
   output logic                 tx_serial_out
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 bitDone;

   assign uart_tx_ready_out = (state_q == IDLE);
   assign accept            = uart_tx_ready_out && uart_tx_en_in;
   assign tx_serial_out     = tx_q;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clear_in    (accept),
      .run_in      (!uart_tx_ready_out),
      .bit_done_out(bitDone)
   );

   // The line value is derived from the next state so it lines up with the state register.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      parity_d = parity_q;
      tx_d     = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = START;
               shift_d  = uart_tx_data_in;
               idx_d    = '0;
               parity_d = (^uart_tx_data_in) ^ (PARITY == PARITY_ODD);
            end
         end
         START: begin
            if (bitDone) state_d = DATA;
         end
         DATA: begin
            if (bitDone) begin
               if (idx_q == LAST_IDX) begin
                  state_d = (PARITY != PARITY_NONE) ? PARITY_BIT : STOP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY_BIT: begin
            if (bitDone) state_d = STOP;
         end
         STOP: begin
            if (bitDone) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      unique case (state_d)
         START:      tx_d = 1'b0;
         DATA:       tx_d = shift_d[0];
         PARITY_BIT: tx_d = parity_d;
         default:    tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/even/odd parity) share stimulus,
// each frame is compared bit by bit against hand-computed line patterns.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] data;
   logic       txArr [3];
   logic       rdyArr[3];

   int total  = 0;
   int passed = 0;

   typedef struct {
      string      name;
      logic [7:0] data;
      int         sel;
      logic [10:0] expFrame;
      int         nBits;
      bit         busyPulses;
   } vec_t;

   vec_t vecs[6];

   uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0)) dut0 (
      .clk_in(clk), .rst_in(rst), .uart_tx_en_in(en), .uart_tx_data_in(data),
      .uart_tx_ready_out(rdyArr[0]), .tx_serial_out(txArr[0]));
   uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1)) dut1 (
      .clk_in(clk), .rst_in(rst), .uart_tx_en_in(en), .uart_tx_data_in(data),
      .uart_tx_ready_out(rdyArr[1]), .tx_serial_out(txArr[1]));
   uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2)) dut2 (
      .clk_in(clk), .rst_in(rst), .uart_tx_en_in(en), .uart_tx_data_in(data),
      .uart_tx_ready_out(rdyArr[2]), .tx_serial_out(txArr[2]));

   always #5 clk = ~clk;

   function automatic vec_t mkVec(string n, logic [7:0] d, int s, logic [10:0] f, int nb, bit b);
      vec_t v;
      v.name = n; v.data = d; v.sel = s; v.expFrame = f; v.nBits = nb; v.busyPulses = b;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end else begin
         passed++;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      @(negedge clk);
      en   = 1'b1;
      data = d;
      @(posedge clk);
   endtask

   task automatic waitAllIdle();
      int n = 0;
      while (!(rdyArr[0] && rdyArr[1] && rdyArr[2]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("idle timeout", 0, 1);
   endtask

   // Called right after the accept edge; newData is driven while busy and must not leak in.
   task automatic sampleFrame(input string name, input int sel, input logic [10:0] exp,
                              input int nBits, input logic [7:0] newData,
                              input bit keepEn, input bit busyPulses);
      int   low = 0;
      logic obs;
      for (int k = 0; k < nBits; k++) begin
         obs = exp[k];
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (4*k + j == 0) begin
               data = newData;
               if (!keepEn) en = 1'b0;
            end
            if (busyPulses) begin
               if (4*k + j == 4 || 4*k + j == 19) begin
                  en   = 1'b1;
                  data = 8'hAA;
               end else if (4*k + j == 5 || 4*k + j == 20) begin
                  en = 1'b0;
               end
            end
            if (txArr[sel] !== exp[k]) obs = txArr[sel];
            if (rdyArr[sel] !== 1'b1) low++;
         end
         checkOutput($sformatf("%s bit%0d", name, k), 32'(obs), 32'(exp[k]));
      end
      @(negedge clk);
      checkOutput($sformatf("%s busy cycles", name), low, nBits * 4);
      checkOutput($sformatf("%s ready after", name), 32'(rdyArr[sel]), 1);
      checkOutput($sformatf("%s line after", name), 32'(txArr[sel]), 1);
   endtask

   initial begin
      logic quiet;
      clk  = 1'b0;
      rst  = 1'b1;
      en   = 1'b0;
      data = 8'h00;

      vecs[0] = mkVec("p0_77",   8'h77, 0, 11'h2EE, 10, 1'b0);
      vecs[1] = mkVec("even_72", 8'h72, 1, 11'h4E4, 11, 1'b0);
      vecs[2] = mkVec("odd_72",  8'h72, 2, 11'h6E4, 11, 1'b0);
      vecs[3] = mkVec("busy_55", 8'h55, 0, 11'h2AA, 10, 1'b1);
      vecs[4] = mkVec("even_01", 8'h01, 1, 11'h602, 11, 1'b0);
      vecs[5] = mkVec("odd_01",  8'h01, 2, 11'h402, 11, 1'b0);

      #1;
      checkOutput("reset line", 32'(txArr[0]), 1);
      checkOutput("reset ready", 32'(rdyArr[0]), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         waitAllIdle();
         applyStimulus(vecs[i].data);
         sampleFrame(vecs[i].name, vecs[i].sel, vecs[i].expFrame, vecs[i].nBits,
                     8'hC3, 1'b0, vecs[i].busyPulses);
         if (vecs[i].busyPulses) begin
            quiet = 1'b1;
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               if (txArr[0] !== 1'b1 || rdyArr[0] !== 1'b1) quiet = 1'b0;
            end
            checkOutput("busy no second frame", 32'(quiet), 1);
         end
      end

      // Streaming: en stays high, so the second frame follows after one idle cycle.
      waitAllIdle();
      applyStimulus(8'h00);
      sampleFrame("stream_00", 0, 11'h200, 10, 8'hFF, 1'b1, 1'b0);
      @(posedge clk);
      sampleFrame("stream_FF", 0, 11'h3FE, 10, 8'h00, 1'b0, 1'b0);

      // Reset in the middle of data bit 3, then an immediate new request.
      waitAllIdle();
      applyStimulus(8'h0F);
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (c == 0) en = 1'b0;
      end
      rst = 1'b1;
      #1;
      checkOutput("midreset line", 32'(txArr[0]), 1);
      checkOutput("midreset ready0", 32'(rdyArr[0]), 1);
      checkOutput("midreset ready1", 32'(rdyArr[1]), 1);
      checkOutput("midreset ready2", 32'(rdyArr[2]), 1);
      @(negedge clk);
      rst  = 1'b0;
      en   = 1'b1;
      data = 8'h3C;
      @(posedge clk);
      sampleFrame("after_reset_3C", 0, 11'h278, 10, 8'h00, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: payload width per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: clk_in cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have port clk_in, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port uart_tx_en_in, input, 1: send request; qualified only when uart_tx_ready_out=1.
REQ-007 SHALL have port uart_tx_data_in, input, DATA_BITS: payload byte; sampled on the accept edge.
REQ-008 SHALL have port uart_tx_ready_out, output, 1: high only in IDLE; transmitter can accept a byte.
REQ-009 SHALL have port tx_serial_out, output, 1: serial line, idle-high, registered.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY_BIT, STOP.
- PARITY_BIT is visited only when PARITY != 0.
REQ-011 SHALL define the accept edge as a rising clk_in edge with uart_tx_en_in=1 and uart_tx_ready_out=1.
- On that edge: latch uart_tx_data_in into a shift register; go IDLE -> START.
REQ-012 SHALL deassert uart_tx_ready_out in the cycle immediately after the accept edge.
- A requester that holds uart_tx_en_in high for one cycle therefore launches exactly one frame.
REQ-013 SHALL ignore uart_tx_en_in and uart_tx_data_in while uart_tx_ready_out=0.
- No queuing; a busy-time change on uart_tx_data_in does not alter the frame in flight.
REQ-014 SHALL drive tx_serial_out = 0 for exactly CLKS_PER_BIT cycles in START.
REQ-015 SHALL send DATA_BITS data bits, LSB first, CLKS_PER_BIT cycles each, in DATA.
REQ-016 SHALL, when PARITY=1, send a parity bit equal to the XOR of the data bits.
- When PARITY=2, send its inverse.
- Either way, for CLKS_PER_BIT cycles in PARITY_BIT.
REQ-017 SHALL drive tx_serial_out = 1 for CLKS_PER_BIT cycles in STOP, then go to IDLE.
REQ-018 SHALL keep uart_tx_ready_out = 0 for exactly N*CLKS_PER_BIT cycles after the accept edge.
- N = DATA_BITS + 2, plus 1 if PARITY != 0.
REQ-019 SHALL hold tx_serial_out = 1 and uart_tx_ready_out = 1 in IDLE.
- uart_tx_en_in held continuously high gives back-to-back frames separated by exactly 1 idle cycle.
REQ-020 SHALL use a baud counter of ceil(log2(CLKS_PER_BIT)) bits.
- Counter restarts at 0 on every bit boundary and on the accept edge; never free-running across frames.
REQ-021 SHALL use a bit index counter of ceil(log2(DATA_BITS)) bits.
- Leave DATA on the last bit's final cycle; no wrap into a second data pass.

Reset
REQ-022 SHALL, while rst_in=1, force state=IDLE, tx_serial_out=1, uart_tx_ready_out=1, and all counters and the shift register to 0, independent of clk_in.
REQ-023 SHALL, on rst_in asserted mid-frame, abort the frame immediately.
- tx_serial_out returns high asynchronously; no partial bits resume after release.
REQ-024 SHALL accept a request on the first rising edge after rst_in deasserts.

Structure
REQ-025 SHALL take the following from the shared uart_pkg:
- state encoding constants;
- PARITY code constants (NONE=0, EVEN=1, ODD=2);
- the default CLKS_PER_BIT value.
- The future uart_rx reuses the same constants.
REQ-026 SHALL place bit timing in one sub-module, uart_baud_gen.
- It provides the counter plus a one-cycle bit_done pulse, with a clear input driven on the accept edge.

Verification (CLKS_PER_BIT=4, DATA_BITS=8 unless stated)
REQ-027 SHALL check single frame, PARITY=0: en pulse with data 0x77.
- tx_serial_out = 0,1,1,1,0,1,1,1,0,1, each held 4 cycles.
- uart_tx_ready_out low for exactly 40 cycles.
REQ-028 SHALL check parity with data 0x72.
- PARITY=1: parity bit 0.
- PARITY=2: parity bit 1.
- Both: ready low for 44 cycles.
REQ-029 SHALL check busy rejection: en pulses with data 0xAA at cycles 5 and 20 after the accept of 0x55.
- Only the 0x55 frame appears.
- Line returns idle at cycle 40.
REQ-030 SHALL check streaming: uart_tx_en_in held high with data 0x00 then 0xFF.
- Two complete frames.
- Exactly 1 idle-high cycle between the first stop bit and the second start bit.
REQ-031 SHALL check reset mid-frame: rst_in pulsed high during data bit 3 of 0x0F.
- tx_serial_out = 1 and uart_tx_ready_out = 1 immediately.
- A new 0x3C request right after release transmits a correct 0x3C frame.
